uart_autobaud_ctrl: RTL

- Auto-baud controller for the adaptive UART receive path.
- After arming, it watches the raw rx line for a 0x55 sync frame and measures 8 bit cells, from the start-bit falling edge to the bit-8 falling edge.
- It validates the cell widths and the stop bit, then publishes the bit period in clocks for the UART rx/tx counters.
- It sits between the rx pin and the receiver's bit-period input. It holds the configuration until it is re-armed.

---
 rtl/uart_autobaud_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller for the adaptive UART receive path.
// It waits for an idle line, times a 0x55 sync frame over eight bit cells,
// validates every cell against the start-bit width and the stop bit, and then
// publishes the rounded bit period. That value is held until the next re-arm.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   S_WAIT_IDLE  | counting consecutive high samples before arming
//   S_WAIT_START | armed, waiting for the start-bit falling edge
//   S_MEASURE    | timing segments 0..7, checking widths at each edge
//   S_CHK_STOP   | edge_idx 8: closing the last low cell; 9: stop-bit high time
//   S_DONE       | one cycle: new bit period published, lock pulse high
//   S_LOCKED     | holding the measured period, rx ignored until re-arm
module uart_autobaud_ctrl #(
    parameter int unsigned MIN_BIT     = 8,
    parameter int unsigned MAX_BIT     = 8191,
    parameter int unsigned DEFAULT_BIT = 434,
    parameter int unsigned IDLE_CLKS   = 8192
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rx,
    input  logic        i_rearm,
    output logic [12:0] o_bit_cnt,
    output logic        o_locked,
    output logic        o_lock_pulse,
    output logic        o_err_pulse
);

    localparam logic [13:0] LP_MIN       = 14'(MIN_BIT);
    localparam logic [13:0] LP_MAX       = 14'(MAX_BIT);
    localparam logic [15:0] LP_IDLE_LAST = 16'(IDLE_CLKS - 1);
    localparam logic [12:0] LP_DEFAULT   = 13'(DEFAULT_BIT);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CHK_STOP,
        S_DONE,
        S_LOCKED
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [12:0] r_seg_cnt;
    logic [15:0] r_tot_cnt;
    logic [15:0] r_idle_cnt;
    logic [3:0]  r_edge_idx;
    logic [12:0] r_seg0;
    logic [12:0] r_meas;
    logic [12:0] r_bit_cnt;
    logic        r_locked;
    logic        r_lock_pulse;
    logic        r_err_pulse;

    logic        w_fall;
    logic        w_rise;
    logic        w_edge;
    logic [13:0] w_seg_len;
    logic [13:0] w_tol;
    logic [13:0] w_lo;
    logic [13:0] w_hi;
    logic        w_in_range;
    logic        w_in_tol;
    logic        w_seg_bad;
    logic        w_timeout;
    logic        w_stop_done;
    logic [12:0] w_meas;

    assign w_fall = r_rx_prev & ~r_rx_sync;
    assign w_rise = ~r_rx_prev & r_rx_sync;
    assign w_edge = w_fall | w_rise;

    // Width of the running segment including the current clock, so the value
    // seen on an edge cycle is exactly the number of clocks since the last edge.
    assign w_seg_len = {1'b0, r_seg_cnt} + 14'd1;

    assign w_tol      = {3'b000, r_seg0[12:2]};
    assign w_lo       = {1'b0, r_seg0} - w_tol;
    assign w_hi       = {1'b0, r_seg0} + w_tol;
    assign w_in_range = (w_seg_len >= LP_MIN) && (w_seg_len <= LP_MAX);
    assign w_in_tol   = (w_seg_len >= w_lo) && (w_seg_len <= w_hi);
    // Segment 0 is judged on absolute limits, every later one against seg0.
    assign w_seg_bad  = (r_edge_idx == 4'd0) ? !w_in_range : !w_in_tol;
    assign w_timeout  = (w_seg_len > LP_MAX);
    assign w_stop_done = (w_seg_len >= {1'b0, r_meas});

    // tot_cnt lags the eight-cell total by one on the edge cycle; +1 and the
    // +4 rounding term fold into a single +5.
    assign w_meas = 13'((r_tot_cnt + 16'd5) >> 3);

    // Two-flop synchronizer plus history flop for edge detection on rx.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Detection FSM with counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_WAIT_IDLE;
            r_seg_cnt    <= '0;
            r_tot_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_edge_idx   <= '0;
            r_seg0       <= '0;
            r_meas       <= '0;
            r_bit_cnt    <= LP_DEFAULT;
            r_locked     <= 1'b0;
            r_lock_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_lock_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            if (i_rearm && (r_state != S_DONE)) begin
                r_state    <= S_WAIT_IDLE;
                r_idle_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_IDLE: begin
                        if (r_rx_sync) begin
                            if (r_idle_cnt == LP_IDLE_LAST) begin
                                r_state <= S_WAIT_START;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 16'd1;
                            end
                        end else begin
                            r_idle_cnt <= '0;
                        end
                    end
                    S_WAIT_START: begin
                        if (w_fall) begin
                            r_state    <= S_MEASURE;
                            r_seg_cnt  <= '0;
                            r_tot_cnt  <= '0;
                            r_edge_idx <= '0;
                        end
                    end
                    S_MEASURE: begin
                        r_tot_cnt <= r_tot_cnt + 16'd1;
                        if (w_timeout || (w_edge && w_seg_bad)) begin
                            r_state     <= S_WAIT_IDLE;
                            r_idle_cnt  <= '0;
                            r_err_pulse <= 1'b1;
                        end else if (w_edge) begin
                            r_seg_cnt  <= '0;
                            r_edge_idx <= r_edge_idx + 4'd1;
                            if (r_edge_idx == 4'd0) begin
                                r_seg0 <= w_seg_len[12:0];
                            end
                            if (r_edge_idx == 4'd7) begin
                                r_meas  <= w_meas;
                                r_state <= S_CHK_STOP;
                            end
                        end else begin
                            r_seg_cnt <= w_seg_len[12:0];
                        end
                    end
                    S_CHK_STOP: begin
                        if (r_edge_idx == 4'd8) begin
                            // Still inside the last low cell; a rise closes it.
                            if (w_timeout || (w_rise && w_seg_bad)) begin
                                r_state     <= S_WAIT_IDLE;
                                r_idle_cnt  <= '0;
                                r_err_pulse <= 1'b1;
                            end else if (w_rise) begin
                                r_seg_cnt  <= '0;
                                r_edge_idx <= 4'd9;
                            end else begin
                                r_seg_cnt <= w_seg_len[12:0];
                            end
                        end else begin
                            if (w_fall) begin
                                r_state     <= S_WAIT_IDLE;
                                r_idle_cnt  <= '0;
                                r_err_pulse <= 1'b1;
                            end else if (w_stop_done) begin
                                r_state      <= S_DONE;
                                r_bit_cnt    <= r_meas;
                                r_locked     <= 1'b1;
                                r_lock_pulse <= 1'b1;
                            end else begin
                                r_seg_cnt <= w_seg_len[12:0];
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_LOCKED;
                    end
                    S_LOCKED: begin
                        r_state <= S_LOCKED;
                    end
                    default: begin
                        r_state <= S_WAIT_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_bit_cnt    = r_bit_cnt;
    assign o_locked     = r_locked;
    assign o_lock_pulse = r_lock_pulse;
    assign o_err_pulse  = r_err_pulse;

endmodule
